// File: rtl/cpld_romcfg.sv
// ROM slot configuration for a CPLD expansion board: a ROM select register
// plus four remappable slots, reprogrammable only after a three-byte unlock.
module cpld_romcfg #(
  parameter logic [7:0] KEY0     = 8'h52,
  parameter logic [7:0] KEY1     = 8'h4F,
  parameter logic [7:0] KEY2     = 8'h4D,
  parameter logic [7:0] DEF_MAP0 = 8'h01,
  parameter logic [7:0] DEF_MAP1 = 8'h02,
  parameter logic [7:0] DEF_MAP2 = 8'h03,
  parameter logic [7:0] DEF_MAP3 = 8'h04,
  parameter logic [3:0] DEF_EN   = 4'hF,
  parameter logic [3:0] WDOG_MAX = 4'd15
) (
  input  logic       wclk,
  input  logic       reset_b,
  input  logic       psel,
  input  logic [7:0] data,
  input  logic       adr14,
  output logic [7:0] romsel_q,
  output logic [3:0] slot_hit,
  output logic       romdis,
  output logic       unlocked,
  output logic       err,
  output logic [2:0] fsm_state
);

  // Handshake: there is no valid/ready pair; every rising wclk edge is one
  // qualified CPU write, and psel/data are consumed unconditionally on it.

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_K1   = 3'd1;
  localparam logic [2:0] S_K2   = 3'd2;
  localparam logic [2:0] S_CMD  = 3'd3;
  localparam logic [2:0] S_ARG  = 3'd4;

  localparam logic [7:0] CMD_EN   = 8'h20;
  localparam logic [7:0] CMD_LOCK = 8'h30;
  localparam logic [7:0] CMD_DEF  = 8'h40;

  logic [2:0] state_q;
  logic [2:0] state_nxt;
  logic [3:0] wdog_q;
  logic [7:0] map_q [4];
  logic [3:0] slot_en_q;
  logic [1:0] idx_q;
  logic       en_op_q;

  logic wdog_trip;
  logic cmd_slot;
  logic cmd_en;
  logic cmd_def;
  logic cmd_err;
  logic arg_map_wr;
  logic arg_en_wr;

  // A select-port write that would push the counter past WDOG_MAX aborts
  // the unlock session instead.
  assign wdog_trip = !psel && (state_q != S_IDLE) && (wdog_q == WDOG_MAX);

  assign cmd_slot = (data[7:2] == 6'b000100);
  assign cmd_en   = (data == CMD_EN);
  assign cmd_def  = psel && (state_q == S_CMD) && (data == CMD_DEF);
  assign cmd_err  = psel && (state_q == S_CMD) && !cmd_slot && !cmd_en &&
                    (data != CMD_LOCK) && (data != CMD_DEF);

  assign arg_map_wr = psel && (state_q == S_ARG) && !en_op_q;
  assign arg_en_wr  = psel && (state_q == S_ARG) && en_op_q;

  always_comb begin
    state_nxt = state_q;
    if (wdog_trip) begin
      state_nxt = S_IDLE;
    end else if (psel) begin
      case (state_q)
        S_IDLE: state_nxt = (data == KEY0) ? S_K1 : S_IDLE;
        S_K1:   state_nxt = (data == KEY1) ? S_K2 : S_IDLE;
        S_K2:   state_nxt = (data == KEY2) ? S_CMD : S_IDLE;
        S_CMD: begin
          if (cmd_slot || cmd_en) begin
            state_nxt = S_ARG;
          end else if (data == CMD_DEF) begin
            state_nxt = S_CMD;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_ARG:   state_nxt = S_CMD;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge wclk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= S_IDLE;
      unlocked  <= 1'b0;
      wdog_q    <= 4'd0;
      err       <= 1'b0;
      romsel_q  <= 8'h00;
      idx_q     <= 2'd0;
      en_op_q   <= 1'b0;
      slot_en_q <= DEF_EN;
      map_q[0]  <= DEF_MAP0;
      map_q[1]  <= DEF_MAP1;
      map_q[2]  <= DEF_MAP2;
      map_q[3]  <= DEF_MAP3;
    end else begin
      state_q  <= state_nxt;
      unlocked <= (state_nxt == S_CMD) || (state_nxt == S_ARG);

      if (psel || (state_nxt == S_IDLE)) begin
        wdog_q <= 4'd0;
      end else if (state_q != S_IDLE) begin
        wdog_q <= wdog_q + 4'd1;
      end

      if (wdog_trip || cmd_err) begin
        err <= 1'b1;
      end else if (cmd_def) begin
        err <= 1'b0;
      end

      if (!psel) begin
        romsel_q <= data;
      end

      if (psel && (state_q == S_CMD) && (cmd_slot || cmd_en)) begin
        idx_q   <= data[1:0];
        en_op_q <= cmd_en;
      end

      if (cmd_def) begin
        slot_en_q <= DEF_EN;
        map_q[0]  <= DEF_MAP0;
        map_q[1]  <= DEF_MAP1;
        map_q[2]  <= DEF_MAP2;
        map_q[3]  <= DEF_MAP3;
      end else begin
        if (arg_en_wr) begin
          slot_en_q <= data[3:0];
        end
        if (arg_map_wr) begin
          map_q[idx_q] <= data;
        end
      end
    end
  end

  // Decode straight from registers so a map/enable update is visible on
  // the cycle right after the capturing edge.
  always_comb begin
    slot_hit = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      slot_hit[i] = adr14 && slot_en_q[i] && (romsel_q == map_q[i]);
    end
  end

  assign romdis    = |slot_hit;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_cpld_romcfg.sv
// Bench for cpld_romcfg: directed scenarios then weighted random writes,
// all checked against a session-level model of the unlock protocol.
module tb_cpld_romcfg;

  logic       wclk;
  logic       reset_b;
  logic       psel;
  logic [7:0] data;
  logic       adr14;
  logic [7:0] romsel_q;
  logic [3:0] slot_hit;
  logic       romdis;
  logic       unlocked;
  logic       err;
  logic [2:0] fsm_state;

  int checks = 0;
  int errors = 0;

  cpld_romcfg dut (
    .wclk      (wclk),
    .reset_b   (reset_b),
    .psel      (psel),
    .data      (data),
    .adr14     (adr14),
    .romsel_q  (romsel_q),
    .slot_hit  (slot_hit),
    .romdis    (romdis),
    .unlocked  (unlocked),
    .err       (err),
    .fsm_state (fsm_state)
  );

  // Model: m_keys counts matched key bytes (3 = unlocked), m_pend is the
  // pending argument (-1 none, 0..3 slot map, 4 enable mask).
  logic [7:0] key_tab [3];
  logic [7:0] def_tab [4];
  logic [7:0] m_romsel;
  logic [7:0] m_map [4];
  logic [3:0] m_en;
  logic       m_err;
  int         m_keys;
  int         m_pend;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_romsel = 8'h00;
    for (int i = 0; i < 4; i++) m_map[i] = def_tab[i];
    m_en   = 4'hF;
    m_err  = 1'b0;
    m_keys = 0;
    m_pend = -1;
    m_cnt  = 0;
  endtask

  task automatic m_write(input logic p, input logic [7:0] d);
    if (!p) begin
      m_romsel = d;
      if (m_keys > 0) begin
        if (m_cnt == 15) begin
          m_keys = 0;
          m_pend = -1;
          m_cnt  = 0;
          m_err  = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end else begin
      m_cnt = 0;
      if (m_pend == 4) begin
        m_en   = d[3:0];
        m_pend = -1;
      end else if (m_pend >= 0) begin
        m_map[m_pend] = d;
        m_pend = -1;
      end else if (m_keys < 3) begin
        m_keys = (d == key_tab[m_keys]) ? m_keys + 1 : 0;
      end else if (d >= 8'h10 && d <= 8'h13) begin
        m_pend = int'(d) - 16;
      end else if (d == 8'h20) begin
        m_pend = 4;
      end else if (d == 8'h30) begin
        m_keys = 0;
      end else if (d == 8'h40) begin
        for (int i = 0; i < 4; i++) m_map[i] = def_tab[i];
        m_en  = 4'hF;
        m_err = 1'b0;
      end else begin
        m_err  = 1'b1;
        m_keys = 0;
      end
    end
  endtask

  function automatic logic [3:0] m_hit(input logic a14);
    logic [3:0] h;
    for (int i = 0; i < 4; i++) h[i] = a14 && m_en[i] && (m_romsel == m_map[i]);
    return h;
  endfunction

  // Compares all outputs against the model; takes 2 time units.
  task automatic check_all(input string tag);
    chk({tag, "_romsel"}, romsel_q, m_romsel);
    chk({tag, "_unlocked"}, unlocked, m_keys == 3);
    chk({tag, "_err"}, err, m_err);
    chk({tag, "_state"}, fsm_state, (m_pend >= 0) ? 4 : m_keys);
    adr14 = 1'b1;
    #1;
    chk({tag, "_hit_hi"}, slot_hit, m_hit(1'b1));
    chk({tag, "_romdis"}, romdis, |m_hit(1'b1));
    adr14 = 1'b0;
    #1;
    chk({tag, "_hit_lo"}, slot_hit, 4'b0000);
  endtask

  task automatic wr(input string tag, input logic p, input logic [7:0] d);
    psel = p;
    data = d;
    #2 wclk = 1'b1;
    #1;
    m_write(p, d);
    check_all(tag);
    #2 wclk = 1'b0;
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_b = 1'b0;
    #1;
    m_reset();
    check_all(tag);
    reset_b = 1'b1;
    #1;
  endtask

  task automatic unlock(input string tag);
    wr(tag, 1'b1, 8'h52);
    wr(tag, 1'b1, 8'h4F);
    wr(tag, 1'b1, 8'h4D);
  endtask

  // Probes each slot's map by selecting it, so map contents are observed.
  task automatic probe_maps(input string tag);
    for (int i = 0; i < 4; i++) wr(tag, 1'b0, m_map[i]);
  endtask

  initial begin
    key_tab = '{8'h52, 8'h4F, 8'h4D};
    def_tab = '{8'h01, 8'h02, 8'h03, 8'h04};
    wclk    = 1'b0;
    reset_b = 1'b1;
    psel    = 1'b0;
    data    = 8'h00;
    adr14   = 1'b0;
    #1;
    do_reset("rst0");

    // Select ROM 3 lands on slot 2.
    wr("sel03", 1'b0, 8'h03);
    adr14 = 1'b1;
    #1;
    chk("sel03_hit_lit", slot_hit, 4'b0100);
    chk("sel03_romdis_lit", romdis, 1'b1);
    adr14 = 1'b0;

    // Remap slot 1 to ROM 7.
    unlock("map1");
    wr("map1_cmd", 1'b1, 8'h11);
    wr("map1_arg", 1'b1, 8'h07);
    wr("map1_sel", 1'b0, 8'h07);
    adr14 = 1'b1;
    #1;
    chk("map1_hit_lit", slot_hit, 4'b0010);
    chk("map1_unl_lit", unlocked, 1'b1);
    adr14 = 1'b0;

    // Enable mask then lock.
    wr("en_cmd", 1'b1, 8'h20);
    wr("en_arg", 1'b1, 8'h05);
    wr("lock", 1'b1, 8'h30);
    chk("lock_unl_lit", unlocked, 1'b0);
    probe_maps("en_probe");

    // Broken key sequence never unlocks and never flags.
    wr("badkey", 1'b1, 8'h52);
    wr("badkey", 1'b1, 8'h4F);
    wr("badkey", 1'b1, 8'h00);
    wr("badkey", 1'b1, 8'h4D);
    chk("badkey_err_lit", err, 1'b0);

    // Watchdog: 15 select writes are tolerated, a psel=1 write rearms it.
    unlock("wd15");
    for (int i = 0; i < 15; i++) wr("wd15", 1'b0, 8'($urandom_range(0, 255)));
    chk("wd15_unl_lit", unlocked, 1'b1);
    wr("wd15_cmd", 1'b1, 8'h40);
    for (int i = 0; i < 16; i++) wr("wd16", 1'b0, 8'($urandom_range(0, 255)));
    chk("wd16_unl_lit", unlocked, 1'b0);
    chk("wd16_err_lit", err, 1'b1);
    unlock("wd_clr");
    wr("wd_clr_def", 1'b1, 8'h40);
    chk("wd_clr_err_lit", err, 1'b0);
    probe_maps("def_probe");

    // Reset between command and argument leaves map1 at default.
    unlock("rstmid");
    wr("rstmid_cmd", 1'b1, 8'h11);
    do_reset("rstmid_rst");
    probe_maps("rstmid_probe");
    unlock("badcmd");
    wr("badcmd", 1'b1, 8'h55);
    chk("badcmd_err_lit", err, 1'b1);
    chk("badcmd_unl_lit", unlocked, 1'b0);

    // Weighted random traffic.
    for (int n = 0; n < 600; n++) begin
      logic       p;
      logic [7:0] d;
      int         r;
      p = ($urandom_range(0, 99) < 55);
      r = $urandom_range(0, 99);
      d = 8'($urandom_range(0, 255));
      if (p) begin
        if (m_pend == 4) begin
          d = 8'($urandom_range(0, 255));
        end else if (m_pend >= 0) begin
          d = 8'($urandom_range(0, 9));
        end else if (m_keys < 3) begin
          if (r < 85) d = key_tab[m_keys];
        end else begin
          case (r % 10)
            0, 1, 2: d = 8'h10 + 8'($urandom_range(0, 3));
            3, 4:    d = 8'h20;
            5:       d = 8'h30;
            6:       d = 8'h40;
            default: ;
          endcase
        end
      end else if (r < 60) begin
        d = m_map[$urandom_range(0, 3)];
      end
      wr("rnd", p, d);
      if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
